// File: rtl/ex_pkg.sv
// ex_pkg: shared constants and types for the execute stage.
//   - datapath width and multiplier iteration count
//   - ALUOp encodings (from the control unit) and R-type funct codes
//   - multiplier FSM state encoding
//   - helper that recognises the MULT instruction
package ex_pkg;

  localparam int EX_W       = 32;
  localparam int EX_MUL_CYC = 32;

  // ALUOp field of EnEX
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;

  // R-type funct field (SignEx[5:0])
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  function automatic logic is_mult_op(input logic [2:0] aluop, input logic [5:0] funct);
    return (aluop == ALUOP_RTYPE) && (funct == FN_MULT);
  endfunction

endpackage

// File: rtl/seq_mult.sv
// seq_mult: signed iterative multiplier, sign/magnitude, one multiplier bit per cycle.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   i_start      begin a multiply (sampled only in IDLE)
//   i_abort      drop any multiply in progress and return to IDLE
//   i_a, i_b     signed operands, captured when the multiply starts
//   o_busy       FSM is iterating (BUSY)
//   o_done       FSM is in DONE; o_prod is the final signed product this cycle
//   o_prod       signed 2W-bit product
module seq_mult
  import ex_pkg::*;
#(
  parameter int W       = EX_W,
  parameter int MUL_CYC = EX_MUL_CYC
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic           i_abort,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*W-1:0] o_prod
);

  localparam int CW = $clog2(MUL_CYC);

  mul_state_e     r_state;
  mul_state_e     w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_mcand;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_mplier;
  logic           r_sign;
  logic [W-1:0]   w_abs_a;
  logic [W-1:0]   w_abs_b;
  logic           w_load;
  logic           w_step;

  // Magnitudes; -2^(W-1) maps onto 2^(W-1), which is exact as an unsigned value.
  assign w_abs_a = i_a[W-1] ? ({W{1'b0}} - i_a) : i_a;
  assign w_abs_b = i_b[W-1] ? ({W{1'b0}} - i_b) : i_b;

  assign w_load = (r_state == MUL_IDLE) && i_start && !i_abort;
  assign w_step = (r_state == MUL_BUSY) && !i_abort;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MUL_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MUL_IDLE: begin
        if (i_start && !i_abort) begin
          w_state_nxt = MUL_BUSY;
        end else begin
          w_state_nxt = MUL_IDLE;
        end
      end
      MUL_BUSY: begin
        if (i_abort) begin
          w_state_nxt = MUL_IDLE;
        end else if (r_cnt == CW'(MUL_CYC - 1)) begin
          w_state_nxt = MUL_DONE;
        end else begin
          w_state_nxt = MUL_BUSY;
        end
      end
      MUL_DONE: w_state_nxt = MUL_IDLE;
      default:  w_state_nxt = MUL_IDLE;
    endcase
  end

  // Shift-add datapath: multiplicand moves left, multiplier moves right, one bit per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= {CW{1'b0}};
      r_mcand  <= {2*W{1'b0}};
      r_acc    <= {2*W{1'b0}};
      r_mplier <= {W{1'b0}};
      r_sign   <= 1'b0;
    end else if (w_load) begin
      r_cnt    <= {CW{1'b0}};
      r_mcand  <= {{W{1'b0}}, w_abs_a};
      r_acc    <= {2*W{1'b0}};
      r_mplier <= w_abs_b;
      r_sign   <= i_a[W-1] ^ i_b[W-1];
    end else if (w_step) begin
      r_cnt    <= r_cnt + CW'(1);
      r_mcand  <= {r_mcand[2*W-2:0], 1'b0};
      r_acc    <= r_mplier[0] ? (r_acc + r_mcand) : r_acc;
      r_mplier <= {1'b0, r_mplier[W-1:1]};
      r_sign   <= r_sign;
    end else begin
      r_cnt    <= r_cnt;
      r_mcand  <= r_mcand;
      r_acc    <= r_acc;
      r_mplier <= r_mplier;
      r_sign   <= r_sign;
    end
  end

  assign o_busy = (r_state == MUL_BUSY);
  assign o_done = (r_state == MUL_DONE);
  assign o_prod = r_sign ? ({2*W{1'b0}} - r_acc) : r_acc;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: pipeline execute stage and EX/MEM register.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   Adder, RD1, RD2       PC+4 and register operands from ID/EX
//   SignEx                sign-extended immediate; [5:0] is funct for R-type
//   Ins20, Ins15          rt / rd destination candidates
//   EnWB, EnM, EnEX       control groups; WB/M pass through, EX steers this stage
//   flush                 squash the instruction currently in EX
//   stall                 combinational hold request for PC, IF/ID, ID/EX
//   sBrAddr .. sM         EX/MEM register outputs (branch target, ALU result,
//                         zero flag, store data, destination reg, WB/M controls)
module ex_stage
  import ex_pkg::*;
#(
  parameter int W       = EX_W,
  parameter int MUL_CYC = EX_MUL_CYC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] Adder,
  input  logic [W-1:0] RD1,
  input  logic [W-1:0] RD2,
  input  logic [W-1:0] SignEx,
  input  logic [4:0]   Ins20,
  input  logic [4:0]   Ins15,
  input  logic [1:0]   EnWB,
  input  logic [2:0]   EnM,
  input  logic [4:0]   EnEX,
  input  logic         flush,
  output logic         stall,
  output logic [W-1:0] sBrAddr,
  output logic [W-1:0] sALURes,
  output logic         sZero,
  output logic [W-1:0] sRD2,
  output logic [4:0]   sWReg,
  output logic [1:0]   sWB,
  output logic [2:0]   sM
);

  logic           w_regdst;
  logic           w_alusrc;
  logic [2:0]     w_aluop;
  logic [5:0]     w_funct;
  logic [W-1:0]   w_opb;
  logic           w_lt;
  logic [W-1:0]   w_alu_res;
  logic [W-1:0]   w_br_addr;
  logic [4:0]     w_wreg;
  logic           w_is_mult;
  logic           w_mul_busy;
  logic           w_mul_done;
  logic           w_mul_idle;
  logic [2*W-1:0] w_prod;
  logic           w_stall;

  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_lo;
  logic [W-1:0]   r_br_addr;
  logic [W-1:0]   r_alu_res;
  logic           r_zero;
  logic [W-1:0]   r_rd2;
  logic [4:0]     r_wreg;
  logic [1:0]     r_wb;
  logic [2:0]     r_m;

  assign w_regdst  = EnEX[4];
  assign w_alusrc  = EnEX[3];
  assign w_aluop   = EnEX[2:0];
  assign w_funct   = SignEx[5:0];
  assign w_opb     = w_alusrc ? SignEx : RD2;
  assign w_lt      = $signed(RD1) < $signed(w_opb);
  assign w_br_addr = Adder + {SignEx[W-3:0], 2'b00};
  assign w_wreg    = w_regdst ? Ins15 : Ins20;
  assign w_is_mult = is_mult_op(w_aluop, w_funct);

  seq_mult #(
    .W       (W),
    .MUL_CYC (MUL_CYC)
  ) u_mult (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_is_mult),
    .i_abort (flush),
    .i_a     (RD1),
    .i_b     (RD2),
    .o_busy  (w_mul_busy),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );

  assign w_mul_idle = !w_mul_busy && !w_mul_done;

  // Stall covers the launch cycle plus every iteration; DONE releases the pipeline.
  assign w_stall = !rst && !flush && ((w_is_mult && w_mul_idle) || w_mul_busy);
  assign stall   = w_stall;

  // ALU; MULT itself produces 0 since its result goes to HI/LO
  always_comb begin
    w_alu_res = {W{1'b0}};
    case (w_aluop)
      ALUOP_ADD: w_alu_res = RD1 + w_opb;
      ALUOP_SUB: w_alu_res = RD1 - w_opb;
      ALUOP_AND: w_alu_res = RD1 & w_opb;
      ALUOP_OR:  w_alu_res = RD1 | w_opb;
      ALUOP_SLT: w_alu_res = {{(W-1){1'b0}}, w_lt};
      ALUOP_RTYPE: begin
        case (w_funct)
          FN_ADD:  w_alu_res = RD1 + w_opb;
          FN_SUB:  w_alu_res = RD1 - w_opb;
          FN_AND:  w_alu_res = RD1 & w_opb;
          FN_OR:   w_alu_res = RD1 | w_opb;
          FN_NOR:  w_alu_res = ~(RD1 | w_opb);
          FN_SLT:  w_alu_res = {{(W-1){1'b0}}, w_lt};
          FN_MFHI: w_alu_res = r_hi;
          FN_MFLO: w_alu_res = r_lo;
          default: w_alu_res = {W{1'b0}};
        endcase
      end
      default: w_alu_res = {W{1'b0}};
    endcase
  end

  // HI/LO: written only when a non-flushed MULT completes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= {W{1'b0}};
      r_lo <= {W{1'b0}};
    end else if (w_mul_done && !flush) begin
      r_hi <= w_prod[2*W-1:W];
      r_lo <= w_prod[W-1:0];
    end else begin
      r_hi <= r_hi;
      r_lo <= r_lo;
    end
  end

  // EX/MEM register; stall or flush inserts a bubble by clearing only the control groups
  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_addr <= {W{1'b0}};
      r_alu_res <= {W{1'b0}};
      r_zero    <= 1'b0;
      r_rd2     <= {W{1'b0}};
      r_wreg    <= 5'd0;
      r_wb      <= 2'b00;
      r_m       <= 3'b000;
    end else if (w_stall || flush) begin
      r_wb      <= 2'b00;
      r_m       <= 3'b000;
    end else begin
      r_br_addr <= w_br_addr;
      r_alu_res <= w_alu_res;
      r_zero    <= (w_alu_res == {W{1'b0}});
      r_rd2     <= RD2;
      r_wreg    <= w_wreg;
      // MULT writes HI/LO, never the register file
      r_wb      <= w_is_mult ? {1'b0, EnWB[0]} : EnWB;
      r_m       <= EnM;
    end
  end

  assign sBrAddr = r_br_addr;
  assign sALURes = r_alu_res;
  assign sZero   = r_zero;
  assign sRD2    = r_rd2;
  assign sWReg   = r_wreg;
  assign sWB     = r_wb;
  assign sM      = r_m;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed-vector bench for ex_stage with hand-computed expectations.
module tb_ex_stage;
  import ex_pkg::*;

  localparam int W = 32;
  localparam logic [4:0] EX_R   = 5'b10010;  // RegDst=1, ALUSrc=0, ALUOp=010
  localparam logic [4:0] EX_LW  = 5'b01000;  // RegDst=0, ALUSrc=1, add
  localparam logic [4:0] EX_BEQ = 5'b00001;  // RegDst=0, ALUSrc=0, sub

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] Adder, RD1, RD2, SignEx;
  logic [4:0]   Ins20, Ins15;
  logic [1:0]   EnWB;
  logic [2:0]   EnM;
  logic [4:0]   EnEX;
  logic         flush;
  logic         stall;
  logic [W-1:0] sBrAddr, sALURes, sRD2;
  logic         sZero;
  logic [4:0]   sWReg;
  logic [1:0]   sWB;
  logic [2:0]   sM;

  int n_vec = 0;
  int n_err = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .Adder(Adder), .RD1(RD1), .RD2(RD2), .SignEx(SignEx),
    .Ins20(Ins20), .Ins15(Ins15), .EnWB(EnWB), .EnM(EnM), .EnEX(EnEX), .flush(flush),
    .stall(stall), .sBrAddr(sBrAddr), .sALURes(sALURes), .sZero(sZero), .sRD2(sRD2),
    .sWReg(sWReg), .sWB(sWB), .sM(sM)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] en_ex, input logic [W-1:0] rd1, input logic [W-1:0] rd2,
                       input logic [W-1:0] sx, input logic [1:0] wb, input logic [2:0] m);
    EnEX = en_ex; RD1 = rd1; RD2 = rd2; SignEx = sx; EnWB = wb; EnM = m;
  endtask

  task automatic alu_r(input string tag, input logic [5:0] fn, input logic [W-1:0] rd1,
                       input logic [W-1:0] rd2, input logic [W-1:0] exp);
    drive(EX_R, rd1, rd2, {26'd0, fn}, 2'b10, 3'b000);
    tick;
    check_val(tag, sALURes, exp);
  endtask

  // Runs one MULT to completion: counts stall cycles, checks bubbles and the DONE capture
  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc;
    int bad;
    drive(EX_R, a, b, {26'd0, FN_MULT}, 2'b11, 3'b011);
    #1;
    cyc = 0;
    bad = 0;
    while (stall === 1'b1 && cyc < 40) begin
      cyc++;
      tick;
      if (sWB !== 2'b00 || sM !== 3'b000) bad++;
    end
    check_val("mult_stall_cycles", 64'(cyc), 64'd33);
    check_val("mult_bubbles", 64'(bad), 64'd0);
    tick;
    check_val("mult_wb_forced", {62'd0, sWB}, 64'd1);
    check_val("mult_m_pass", {61'd0, sM}, 64'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // 1: reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      Adder = $urandom; RD1 = $urandom; RD2 = $urandom; SignEx = $urandom;
      Ins20 = 5'($urandom); Ins15 = 5'($urandom); EnWB = 2'($urandom);
      EnM = 3'($urandom); EnEX = 5'($urandom); flush = 1'($urandom);
      #1;
      check_val("rst_stall", {63'd0, stall}, 64'd0);
      tick;
    end
    check_val("rst_braddr", {32'd0, sBrAddr}, 64'd0);
    check_val("rst_alures", {32'd0, sALURes}, 64'd0);
    check_val("rst_zero",   {63'd0, sZero}, 64'd0);
    check_val("rst_rd2",    {32'd0, sRD2}, 64'd0);
    check_val("rst_wreg",   {59'd0, sWReg}, 64'd0);
    check_val("rst_wb",     {62'd0, sWB}, 64'd0);
    check_val("rst_m",      {61'd0, sM}, 64'd0);
    rst = 1'b0; flush = 1'b0; Adder = 32'h0; Ins20 = 5'd9; Ins15 = 5'd3;
    drive(EX_R, 32'h0, 32'h0, {26'd0, FN_MFHI}, 2'b10, 3'b000);
    #1;
    check_val("idle_stall", {63'd0, stall}, 64'd0);
    tick;
    check_val("mfhi_after_rst", {32'd0, sALURes}, 64'd0);
    check_val("mfhi_wb", {62'd0, sWB}, 64'd2);

    // 2: R-type add wrap to zero, slt both directions, other functs
    alu_r("r_add_wrap", FN_ADD, 32'd7, 32'hFFFF_FFF9, 32'd0);
    check_val("r_add_zero", {63'd0, sZero}, 64'd1);
    check_val("r_add_wreg", {59'd0, sWReg}, 64'd3);
    alu_r("slt_7_m7", FN_SLT, 32'd7, 32'hFFFF_FFF9, 32'd0);
    check_val("slt_7_m7_zero", {63'd0, sZero}, 64'd1);
    alu_r("slt_m7_7", FN_SLT, 32'hFFFF_FFF9, 32'd7, 32'd1);
    check_val("slt_m7_7_zero", {63'd0, sZero}, 64'd0);
    alu_r("r_sub",  FN_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
    alu_r("r_and",  FN_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    alu_r("r_or",   FN_OR,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
    alu_r("r_nor",  FN_NOR, 32'h0, 32'h0, 32'hFFFF_FFFF);
    alu_r("r_bad_funct", 6'h3F, 32'd5, 32'd5, 32'd0);
    drive(5'b00110, 32'd5, 32'd3, 32'h0, 2'b00, 3'b000);
    tick;
    check_val("aluop_110", {32'd0, sALURes}, 64'd0);
    drive(5'b01101, 32'hFFFF_FFFF, 32'h0, 32'h0, 2'b00, 3'b000);
    tick;
    check_val("aluop_slt_imm", {32'd0, sALURes}, 64'd1);
    drive(5'b01011, 32'h0000_ABCD, 32'h0, 32'h0000_00FF, 2'b00, 3'b000);
    tick;
    check_val("aluop_and_imm", {32'd0, sALURes}, 64'h0000_00CD);
    drive(5'b01100, 32'h0000_A000, 32'h0, 32'h0000_000B, 2'b00, 3'b000);
    tick;
    check_val("aluop_or_imm", {32'd0, sALURes}, 64'h0000_A00B);

    // 3: beq-type branch target
    Adder = 32'h0000_0100;
    drive(EX_BEQ, 32'h55, 32'h55, 32'hFFFF_FFFE, 2'b00, 3'b100);
    tick;
    check_val("beq_braddr", {32'd0, sBrAddr}, 64'h0000_00F8);
    check_val("beq_zero", {63'd0, sZero}, 64'd1);
    check_val("beq_m", {61'd0, sM}, 64'd4);
    check_val("beq_rd2", {32'd0, sRD2}, 64'h55);

    // 6: lw-type vs R-type destination and pass-through latency
    drive(EX_LW, 32'h0000_1000, 32'h77, 32'h0000_0010, 2'b11, 3'b010);
    tick;
    check_val("lw_alures", {32'd0, sALURes}, 64'h0000_1010);
    check_val("lw_wreg", {59'd0, sWReg}, 64'd9);
    check_val("lw_wb", {62'd0, sWB}, 64'd3);
    check_val("lw_m", {61'd0, sM}, 64'd2);
    check_val("lw_rd2", {32'd0, sRD2}, 64'h77);
    drive(EX_R, 32'd1, 32'd2, {26'd0, FN_ADD}, 2'b10, 3'b000);
    #1;
    check_val("wb_latency", {62'd0, sWB}, 64'd3);
    tick;
    check_val("r_wreg", {59'd0, sWReg}, 64'd3);
    check_val("r_alures", {32'd0, sALURes}, 64'd3);
    check_val("r_wb", {62'd0, sWB}, 64'd2);
    check_val("r_m", {61'd0, sM}, 64'd0);

    // 4: MULT -3 * 5
    do_mult(32'hFFFF_FFFD, 32'd5);
    alu_r("mflo_m3x5", FN_MFLO, 32'h0, 32'h0, 32'hFFFF_FFF1);
    alu_r("mfhi_m3x5", FN_MFHI, 32'h0, 32'h0, 32'hFFFF_FFFF);

    // 5: flush in the tenth BUSY cycle of 6*7
    drive(EX_R, 32'd6, 32'd7, {26'd0, FN_MULT}, 2'b11, 3'b011);
    #1;
    check_val("mult67_launch_stall", {63'd0, stall}, 64'd1);
    for (int i = 0; i < 10; i++) tick;
    check_val("mult67_busy_stall", {63'd0, stall}, 64'd1);
    flush = 1'b1;
    #1;
    check_val("flush_stall_drop", {63'd0, stall}, 64'd0);
    tick;
    check_val("flush_wb", {62'd0, sWB}, 64'd0);
    check_val("flush_m", {61'd0, sM}, 64'd0);
    flush = 1'b0;
    drive(EX_R, 32'h0, 32'h0, {26'd0, FN_MFLO}, 2'b10, 3'b000);
    #1;
    check_val("post_flush_stall", {63'd0, stall}, 64'd0);
    tick;
    check_val("flush_lo_kept", {32'd0, sALURes}, 64'hFFFF_FFF1);
    alu_r("flush_hi_kept", FN_MFHI, 32'h0, 32'h0, 32'hFFFF_FFFF);

    // MULT boundaries: by zero with negative sign, then -2^31 squared
    do_mult(32'hFFFF_FFFF, 32'd0);
    alu_r("mfhi_m1x0", FN_MFHI, 32'h0, 32'h0, 32'h0);
    alu_r("mflo_m1x0", FN_MFLO, 32'h0, 32'h0, 32'h0);
    do_mult(32'h8000_0000, 32'h8000_0000);
    alu_r("mfhi_min_sq", FN_MFHI, 32'h0, 32'h0, 32'h4000_0000);
    alu_r("mflo_min_sq", FN_MFLO, 32'h0, 32'h0, 32'h0);

    // Reset in the middle of a MULT aborts it and clears HI/LO
    drive(EX_R, 32'd3, 32'd3, {26'd0, FN_MULT}, 2'b11, 3'b011);
    for (int i = 0; i < 5; i++) tick;
    rst = 1'b1;
    #1;
    check_val("rst_mid_mult_stall", {63'd0, stall}, 64'd0);
    tick;
    rst = 1'b0;
    drive(EX_R, 32'h0, 32'h0, {26'd0, FN_MFHI}, 2'b10, 3'b000);
    #1;
    check_val("post_rst_stall", {63'd0, stall}, 64'd0);
    tick;
    check_val("rst_clears_hi", {32'd0, sALURes}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
